// File: rtl/i2c_slave_regfile.sv
// I2C target with a byte-wide register file and an auto-incrementing pointer.
// SCL/SDA are oversampled on clk. SDA is pulled low through sda_oe, and the
// top level resolves the wired-AND bus. The target never stretches SCL.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         NUM_REGS   = 16,
  parameter int         PTR_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic             busy,
  output logic             wr_valid,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [7:0]       wr_data
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t                         state;
  logic                           scl_p0, scl_p1, scl_p2;
  logic                           sda_p0, sda_p1, sda_p2;
  logic                           scl_rise, scl_fall, start_det, stop_det;
  logic [6:0]                     shreg;
  logic [7:0]                     byte_in;
  logic [6:0]                     tx;
  logic [2:0]                     bitcnt;
  logic                           last_bit;
  logic                           rw;
  logic [PTR_W-1:0]               ptr;
  logic [NUM_REGS-1:0][7:0]       mem;

  // Pointer advance. The natural PTR_W-bit overflow wraps NUM_REGS-1 to 0.
  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return p + PTR_W'(1);
  endfunction

  // Stages p0/p1 synchronize the bus lines into clk. Stage p2 holds the previous sample for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_p0 <= 1'b1; scl_p1 <= 1'b1; scl_p2 <= 1'b1;
      sda_p0 <= 1'b1; sda_p1 <= 1'b1; sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= scl_in; scl_p1 <= scl_p0; scl_p2 <= scl_p1;
      sda_p0 <= sda_in; sda_p1 <= sda_p0; sda_p2 <= sda_p1;
    end
  end

  // Bus events. START and STOP require SCL to be stable high across both samples.
  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
  assign byte_in   = {shreg, sda_p1};
  assign last_bit  = (bitcnt == 3'd7);

  // Protocol FSM. An ACK state drives SDA on its first falling edge and ends on the second; sda_oe marks which edge has passed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_ptr   <= '0;
      wr_data  <= '0;
      ptr      <= '0;
      shreg    <= '0;
      tx       <= '0;
      bitcnt   <= '0;
      rw       <= 1'b0;
      mem      <= '0;
    end else begin
      wr_valid <= 1'b0;
      if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
        bitcnt <= '0;
      end else if (start_det) begin
        state  <= ADDR;
        sda_oe <= 1'b0;
        bitcnt <= '0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shreg  <= {shreg[5:0], sda_p1};
              bitcnt <= bitcnt + 3'd1;
              if (last_bit) begin
                rw <= sda_p1;
                if (byte_in[7:1] == SLAVE_ADDR) begin
                  busy  <= 1'b1;
                  state <= ADDR_ACK;
                end else begin
                  busy  <= 1'b0;
                  state <= IGNORE;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else if (rw) begin
                tx     <= mem[ptr][6:0];
                sda_oe <= ~mem[ptr][7];
                bitcnt <= '0;
                state  <= RD_DATA;
              end else begin
                sda_oe <= 1'b0;
                bitcnt <= '0;
                state  <= PTR;
              end
            end
          end
          PTR: begin
            if (scl_rise) begin
              shreg  <= {shreg[5:0], sda_p1};
              bitcnt <= bitcnt + 3'd1;
              if (last_bit) begin
                ptr   <= byte_in[PTR_W-1:0];
                state <= PTR_ACK;
              end
            end
          end
          PTR_ACK, WR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                bitcnt <= '0;
                state  <= WR_DATA;
              end
            end
          end
          WR_DATA: begin
            if (scl_rise) begin
              shreg  <= {shreg[5:0], sda_p1};
              bitcnt <= bitcnt + 3'd1;
              if (last_bit) begin
                mem[ptr] <= byte_in;
                wr_valid <= 1'b1;
                wr_ptr   <= ptr;
                wr_data  <= byte_in;
                ptr      <= inc_ptr(ptr);
                state    <= WR_ACK;
              end
            end
          end
          RD_DATA: begin
            if (scl_fall) begin
              if (last_bit) begin
                sda_oe <= 1'b0;
                state  <= RD_ACK;
              end else begin
                sda_oe <= ~tx[6];
                tx     <= {tx[5:0], 1'b0};
                bitcnt <= bitcnt + 3'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (sda_p1) begin
                sda_oe <= 1'b0;
                state  <= IGNORE;
              end else begin
                ptr <= inc_ptr(ptr);
              end
            end else if (scl_fall) begin
              tx     <= mem[ptr][6:0];
              sda_oe <= ~mem[ptr][7];
              bitcnt <= '0;
              state  <= RD_DATA;
            end
          end
          IDLE, IGNORE: begin
          end
          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
Synthesizable I2C target (slave) that responds to transactions driven by the bench's I2C master interface. It holds a small byte-wide register file reachable over the bus. The pointer auto-increments across multi-byte accesses. It observes SCL/SDA as inputs and pulls SDA low through an open-drain enable; the top level resolves the wired-AND bus with the pull-up. Runs on the system clock, oversampling the ~100 kHz SCL.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit bus address this target acknowledges
NUM_REGS, 16, number of 8-bit registers (power of 2)
PTR_W, 4, register pointer width = log2(NUM_REGS)

Ports:
clk  input  1  system clock (100 MHz nominal)
rst  input  1  synchronous, active-high reset
scl_in  input  1  resolved SCL bus value (asynchronous to clk)
sda_in  input  1  resolved SDA bus value (asynchronous to clk)
sda_oe  output  1  1 = pull SDA low, 0 = release (high-Z at top level)
busy  output  1  high from an address-matched START until STOP
wr_valid  output  1  one-cycle pulse when a data byte is written to the register file
wr_ptr  output  PTR_W  register index written (valid with wr_valid)
wr_data  output  8  byte written (valid with wr_valid)

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset (synchronous, active-high): sda_oe=0, busy=0, wr_valid=0, wr_ptr=0, wr_data=0, pointer=0, all registers=8'h00, state=IDLE. Reset mid-transaction releases SDA on the next clk edge.
- Input conditioning:
  - scl_in and sda_in each pass through a 2-FF synchronizer plus one history flop.
  - Edge and START/STOP detection lag the bus by 3 clk.
- Conditions:
  - START/repeated START = SDA falls while SCL is high.
  - STOP = SDA rises while SCL is high.
  - Both are detected in any state and take priority over bit handling.
- Bit timing:
  - Sample SDA on the synchronized SCL rising edge.
  - Change sda_oe only on the synchronized SCL falling edge.
  - sda_oe is never changed while SCL is high.
- Bit counter: 3-bit, MSB first. A byte completes on the 8th rising edge.
- States:
  - IDLE: wait for START -> ADDR.
  - ADDR: shift 8 bits {addr[6:0], rw}.
    - If addr==SLAVE_ADDR: assert ACK (sda_oe=1) on the next falling edge -> ADDR_ACK, busy=1.
    - Otherwise: -> IGNORE, sda_oe stays 0.
    - General call 7'h00 is NACKed.
  - ADDR_ACK: on the falling edge ending the ACK bit:
    - rw=0 -> release SDA -> PTR.
    - rw=1 -> drive bit7 of reg[pointer] (sda_oe = ~bit) -> RD_DATA.
  - PTR: shift 8 bits. pointer = byte[PTR_W-1:0] (upper bits ignored). ACK -> PTR_ACK -> WR_DATA.
  - WR_DATA: shift 8 bits, then on the 8th rising edge +1 clk:
    - reg[pointer] = byte; wr_valid pulses; wr_ptr = pointer; wr_data = byte.
    - ACK -> WR_ACK; pointer increments.
  - WR_ACK: release on the falling edge -> WR_DATA.
  - RD_DATA: drive bits 6..0 on successive falling edges. After the 8th bit, release SDA on the falling edge -> RD_ACK.
  - RD_ACK: sample the master bit on the rising edge.
    - ACK (0): pointer increments; next falling edge drives bit7 of the new reg -> RD_DATA.
    - NACK (1): -> IGNORE, SDA released.
  - IGNORE: SDA released; wait for START (-> ADDR) or STOP (-> IDLE).
- Pointer: wraps NUM_REGS-1 -> 0 on increment (read and write).
- STOP in any state: -> IDLE, sda_oe=0, busy=0. A partially shifted byte is discarded (no write, no wr_valid).
- Repeated START in any state: -> ADDR, bit counter cleared, sda_oe=0.
  - Pointer is retained, so write-pointer-then-repeated-START-read reads from the set pointer.
  - busy stays 1 only if the new address matches.
- Write of pointer only followed by STOP: pointer updated, no register written.
- No clock stretching: SCL is never driven.

Test Plan:
- Write: START, 0xA0, ptr 0x03, data 0x5A, 0xC3, STOP -> ACK on all 4 bytes; wr_valid pulses twice (ptr 3/0x5A, ptr 4/0xC3); reg[3]=0x5A, reg[4]=0xC3; busy falls within 3 clk of STOP.
- Combined read: START, 0xA0, ptr 0x03, repeated START, 0xA1, master ACK then NACK -> SDA returns 0x5A then 0xC3; SDA released after the NACK; no wr_valid.
- Wrong address: START, 0xA2, 0x11, STOP -> sda_oe stays 0 throughout; no register change; busy stays 0.
- Wrap: write ptr 0x0F, data 0x11, 0x22 -> reg[15]=0x11, reg[0]=0x22, wr_ptr sequence 15 then 0.
- Abort: STOP after 4 data bits in WR_DATA -> no wr_valid, register unchanged, state IDLE; the next full write succeeds.
- Reset mid-read while sda_oe=1 -> sda_oe=0 on the next clk; all registers read back 0x00 afterwards.
